// File: rtl/decode_pkg.sv
// Shared MIPS decode definitions: opcode/func codes, ALU op codes and the
// decoded-instruction record carried through the decode queue.
package decode_pkg;

  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_J        = 6'h02;
  localparam logic [5:0] OPC_JAL      = 6'h03;
  localparam logic [5:0] OPC_BEQ      = 6'h04;
  localparam logic [5:0] OPC_BNE      = 6'h05;
  localparam logic [5:0] OPC_BGTZ     = 6'h07;
  localparam logic [5:0] OPC_ADDI     = 6'h08;
  localparam logic [5:0] OPC_ADDIU    = 6'h09;
  localparam logic [5:0] OPC_SLTI     = 6'h0A;
  localparam logic [5:0] OPC_SLTIU    = 6'h0B;
  localparam logic [5:0] OPC_ORI      = 6'h0D;
  localparam logic [5:0] OPC_XORI     = 6'h0E;
  localparam logic [5:0] OPC_LUI      = 6'h0F;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OPC_LB       = 6'h20;
  localparam logic [5:0] OPC_LW       = 6'h23;
  localparam logic [5:0] OPC_LBU      = 6'h24;
  localparam logic [5:0] OPC_SB       = 6'h28;
  localparam logic [5:0] OPC_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_MUL   = 6'h02; // SPECIAL2 space
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [5:0] {
    OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_LUI, OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_BGTZ,
    OP_J, OP_JAL, OP_JR, OP_JALR, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_MUL
  } alu_op_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [31:0] imm_ext;
    logic [31:0] target;
    alu_op_e     alu_op;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] insn;
  } decoded_t;

endpackage

// File: rtl/decode_stage_logic.sv
// Purely combinational MIPS decoder: insn/pc -> decoded_t record.
module decode_logic
  import decode_pkg::*;
#(
  parameter int EN_MULDIV = 1
) (
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, pc4, br_tgt, j_tgt;
  logic        legal;

  assign op     = insn[31:26];
  assign fn     = insn[5:0];
  assign rs     = insn[25:21];
  assign rt     = insn[20:16];
  assign rd     = insn[15:11];
  assign sext   = {{16{insn[15]}}, insn[15:0]};
  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {sext[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], insn[25:0], 2'b00};

  // Field extraction and op selection; unused register fields stay 0.
  always_comb begin
    dec        = '0;
    dec.pc     = pc;
    dec.insn   = insn;
    dec.opcode = op;
    dec.alu_op = OP_NOP;
    legal      = 1'b1;
    case (op)
      OPC_SPECIAL: begin
        dec.func = fn;
        dec.rs   = rs;
        dec.rt   = rt;
        dec.rd   = rd;
        case (fn)
          FN_SLL:   begin dec.rs = '0; dec.sa = insn[10:6]; dec.alu_op = OP_SLL; end
          FN_SRL:   begin dec.rs = '0; dec.sa = insn[10:6]; dec.alu_op = OP_SRL; end
          FN_SRA:   begin dec.rs = '0; dec.sa = insn[10:6]; dec.alu_op = OP_SRA; end
          FN_SLLV:  dec.alu_op = OP_SLLV;
          FN_SRLV:  dec.alu_op = OP_SRLV;
          FN_SRAV:  dec.alu_op = OP_SRAV;
          FN_JR:    begin dec.rt = '0; dec.rd = '0; dec.alu_op = OP_JR; end
          FN_JALR:  begin dec.rt = '0; dec.alu_op = OP_JALR; end
          FN_MFHI:  begin dec.rs = '0; dec.rt = '0; dec.alu_op = OP_MFHI; legal = (EN_MULDIV != 0); end
          FN_MFLO:  begin dec.rs = '0; dec.rt = '0; dec.alu_op = OP_MFLO; legal = (EN_MULDIV != 0); end
          FN_MULT:  begin dec.rd = '0; dec.alu_op = OP_MULT;  legal = (EN_MULDIV != 0); end
          FN_MULTU: begin dec.rd = '0; dec.alu_op = OP_MULTU; legal = (EN_MULDIV != 0); end
          FN_DIV:   begin dec.rd = '0; dec.alu_op = OP_DIV;   legal = (EN_MULDIV != 0); end
          FN_DIVU:  begin dec.rd = '0; dec.alu_op = OP_DIVU;  legal = (EN_MULDIV != 0); end
          FN_ADD:   dec.alu_op = OP_ADD;
          FN_ADDU:  dec.alu_op = OP_ADDU;
          FN_SUB:   dec.alu_op = OP_SUB;
          FN_SUBU:  dec.alu_op = OP_SUBU;
          FN_AND:   dec.alu_op = OP_AND;
          FN_OR:    dec.alu_op = OP_OR;
          FN_XOR:   dec.alu_op = OP_XOR;
          FN_NOR:   dec.alu_op = OP_NOR;
          FN_SLT:   dec.alu_op = OP_SLT;
          FN_SLTU:  dec.alu_op = OP_SLTU;
          default:  legal = 1'b0;
        endcase
      end
      OPC_SPECIAL2: begin
        // MUL is presented to execute as an R-type op
        dec.opcode = '0;
        dec.func   = fn;
        dec.rs     = rs;
        dec.rt     = rt;
        dec.rd     = rd;
        dec.alu_op = OP_MUL;
        legal      = (fn == FN_MUL) && (EN_MULDIV != 0);
      end
      OPC_J:    begin dec.imm_ext = {6'b0, insn[25:0]}; dec.target = j_tgt; dec.alu_op = OP_J; end
      OPC_JAL:  begin dec.imm_ext = {6'b0, insn[25:0]}; dec.target = j_tgt; dec.rd = 5'd31; dec.alu_op = OP_JAL; end
      OPC_BEQ:  begin dec.rs = rs; dec.rt = rt; dec.imm_ext = sext; dec.target = br_tgt; dec.alu_op = OP_BEQ; end
      OPC_BNE:  begin dec.rs = rs; dec.rt = rt; dec.imm_ext = sext; dec.target = br_tgt; dec.alu_op = OP_BNE; end
      OPC_BGTZ: begin dec.rs = rs; dec.imm_ext = sext; dec.target = br_tgt; dec.alu_op = OP_BGTZ; end
      OPC_ADDI:  begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_ADD; end
      OPC_ADDIU: begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_ADDU; end
      OPC_SLTI:  begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_SLT; end
      OPC_SLTIU: begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_SLTU; end
      OPC_ORI:   begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = {16'h0, insn[15:0]}; dec.alu_op = OP_OR; end
      OPC_XORI:  begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = {16'h0, insn[15:0]}; dec.alu_op = OP_XOR; end
      OPC_LUI:   begin dec.rt = rt; dec.rd = rt; dec.imm_ext = {insn[15:0], 16'h0}; dec.alu_op = OP_LUI; end
      OPC_LW:    begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_LW; end
      OPC_LB:    begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_LB; end
      OPC_LBU:   begin dec.rs = rs; dec.rt = rt; dec.rd = rt; dec.imm_ext = sext; dec.alu_op = OP_LBU; end
      OPC_SW:    begin dec.rs = rs; dec.rt = rt; dec.imm_ext = sext; dec.alu_op = OP_SW; end
      OPC_SB:    begin dec.rs = rs; dec.rt = rt; dec.imm_ext = sext; dec.alu_op = OP_SB; end
      default:   legal = 1'b0;
    endcase
    // The all-zero word is the canonical NOP, not a shift
    if (insn == 32'h0) dec.alu_op = OP_NOP;
    // Illegal entries keep pc/insn/opcode for the trap path, nothing else
    if (!legal) begin
      dec         = '0;
      dec.pc      = pc;
      dec.insn    = insn;
      dec.opcode  = op;
      dec.alu_op  = OP_NOP;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode into a DEPTH-entry circular queue with
// valid/ready handshake on both sides and a flush that empties the queue.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ALUOP_W   = 6,
  parameter int EN_MULDIV = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        insn,
  input  logic [31:0]        pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         opcode_out,
  output logic [4:0]         rs_out,
  output logic [4:0]         rt_out,
  output logic [4:0]         rd_out,
  output logic [4:0]         sa_out,
  output logic [5:0]         func_out,
  output logic [31:0]        imm_ext_out,
  output logic [31:0]        target_out,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        insn_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  decoded_t                dec, head, last_q;
  decoded_t [DEPTH-1:0]    mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    push, pop;

  decode_logic #(.EN_MULDIV(EN_MULDIV)) u_dec (
    .insn (insn),
    .pc   (pc),
    .dec  (dec)
  );

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Queue storage; contents are only observed while count covers them
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Pointers, occupancy and the last-popped record shown when empty
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : last_q;
  assign opcode_out  = head.opcode;
  assign rs_out      = head.rs;
  assign rt_out      = head.rt;
  assign rd_out      = head.rd;
  assign sa_out      = head.sa;
  assign func_out    = head.func;
  assign imm_ext_out = head.imm_ext;
  assign target_out  = head.target;
  assign alu_op      = ALUOP_W'(head.alu_op);
  assign illegal_out = head.illegal;
  assign pc_out      = head.pc;
  assign insn_out    = head.insn;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, queue ordering, flush, reset.
module tb_decode_stage;
  import decode_pkg::*;

  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] insn = '0, pc = '0;

  logic        in_ready, out_valid, illegal_out;
  logic [5:0]  opcode_out, func_out, alu_op;
  logic [4:0]  rs_out, rt_out, rd_out, sa_out;
  logic [31:0] imm_ext_out, target_out, pc_out, insn_out;

  logic        n_in_ready, n_out_valid, n_illegal;
  logic [5:0]  n_opcode, n_func, n_alu_op;
  logic [4:0]  n_rs, n_rt, n_rd, n_sa;
  logic [31:0] n_imm, n_target, n_pc, n_insn;

  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  decode_stage #(.DEPTH(2), .ALUOP_W(6), .EN_MULDIV(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .insn(insn), .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .opcode_out(opcode_out), .rs_out(rs_out),
    .rt_out(rt_out), .rd_out(rd_out), .sa_out(sa_out), .func_out(func_out),
    .imm_ext_out(imm_ext_out), .target_out(target_out), .alu_op(alu_op),
    .illegal_out(illegal_out), .pc_out(pc_out), .insn_out(insn_out)
  );

  decode_stage #(.DEPTH(2), .ALUOP_W(6), .EN_MULDIV(0)) dut_nomd (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(n_in_ready), .insn(insn), .pc(pc), .out_valid(n_out_valid),
    .out_ready(out_ready), .opcode_out(n_opcode), .rs_out(n_rs),
    .rt_out(n_rt), .rd_out(n_rd), .sa_out(n_sa), .func_out(n_func),
    .imm_ext_out(n_imm), .target_out(n_target), .alu_op(n_alu_op),
    .illegal_out(n_illegal), .pc_out(n_pc), .insn_out(n_insn)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One accepted beat; returns at the following negedge with the entry at head
  task automatic beat(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1; insn = i; pc = p;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_alu_op",    alu_op, OP_NOP);
    chk("rst_imm",       imm_ext_out, 0);
    chk("rst_pc",        pc_out, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // add $3,$1,$2
    beat(32'h00221820, 32'h0);
    chk("add_valid", out_valid, 1);
    chk("add_rs", rs_out, 1);
    chk("add_rt", rt_out, 2);
    chk("add_rd", rd_out, 3);
    chk("add_func", func_out, 6'h20);
    chk("add_aluop", alu_op, OP_ADD);
    chk("add_illegal", illegal_out, 0);
    @(negedge clock);
    chk("empty_valid", out_valid, 0);
    chk("empty_hold_rd", rd_out, 3);

    beat(32'h2408FFFF, 32'h4);
    chk("addiu_imm", imm_ext_out, 32'hFFFFFFFF);
    chk("addiu_rd", rd_out, 8);
    beat(32'h3508FFFF, 32'h8);
    chk("ori_imm", imm_ext_out, 32'h0000FFFF);
    chk("ori_aluop", alu_op, OP_OR);
    beat(32'h3C081234, 32'hC);
    chk("lui_imm", imm_ext_out, 32'h12340000);
    chk("lui_rs", rs_out, 0);
    beat(32'h10220003, 32'h100);
    chk("beq_target", target_out, 32'h110);
    chk("beq_rd", rd_out, 0);
    chk("beq_pc", pc_out, 32'h100);
    beat(32'h1422FFFF, 32'h100);
    chk("bne_back_target", target_out, 32'h100);
    beat(32'h08000010, 32'h40000000);
    chk("j_target", target_out, 32'h40000040);
    chk("j_imm", imm_ext_out, 32'h10);
    beat(32'h0C000010, 32'h40000000);
    chk("jal_rd", rd_out, 31);
    chk("jal_aluop", alu_op, OP_JAL);
    beat(32'h00021080, 32'h0);
    chk("sll_sa", sa_out, 2);
    chk("sll_rd", rd_out, 2);
    chk("sll_aluop", alu_op, OP_SLL);
    beat(32'h00000000, 32'h0);
    chk("nop_aluop", alu_op, OP_NOP);
    chk("nop_illegal", illegal_out, 0);
    beat(32'hFC000000, 32'h0);
    chk("bad_op_illegal", illegal_out, 1);
    chk("bad_op_aluop", alu_op, OP_NOP);
    beat(32'h70221802, 32'h0);
    chk("mul_opcode", opcode_out, 0);
    chk("mul_aluop", alu_op, OP_MUL);
    chk("mul_rd", rd_out, 3);
    chk("nomd_mul_illegal", n_illegal, 1);
    beat(32'h0022001A, 32'h0);
    chk("div_aluop", alu_op, OP_DIV);
    chk("div_illegal", illegal_out, 0);
    chk("nomd_div_illegal", n_illegal, 1);
    chk("nomd_div_aluop", n_alu_op, OP_NOP);
    chk("nomd_div_insn", n_insn, 32'h0022001A);
    @(negedge clock);

    // Fill the queue with execute stalled, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; insn = 32'h24010001;
    @(posedge clock); @(negedge clock);
    chk("fill1_in_ready", in_ready, 1);
    insn = 32'h24020002;
    @(posedge clock); @(negedge clock);
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    chk("full_head", imm_ext_out, 1);
    insn = 32'h24030003;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    chk("stall_head_stable", imm_ext_out, 1);
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("drain2_valid", out_valid, 1);
    chk("drain2_head", imm_ext_out, 2);
    @(posedge clock); @(negedge clock);
    chk("drained_valid", out_valid, 0);
    chk("drained_in_ready", in_ready, 1);
    chk("drained_hold", imm_ext_out, 2);

    // Flush with two queued entries and a beat presented
    out_ready = 1'b0;
    beat(32'h24010001, 32'h0);
    beat(32'h24020002, 32'h0);
    flush = 1'b1; in_valid = 1'b1; insn = 32'h24030003;
    @(posedge clock); @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clock); @(negedge clock);
    chk("flush_beat_dropped", out_valid, 0);
    out_ready = 1'b1;
    beat(32'h24040004, 32'h0);
    chk("post_flush_head", imm_ext_out, 4);
    @(negedge clock);
    chk("post_flush_empty", out_valid, 0);

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    beat(32'h24050005, 32'h0);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_imm", imm_ext_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
